// File: rtl/serial_addsub_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_addsub_ctrl_pkg : shared FSM state encoding and default width
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_addsub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_addsub_ctrl_if : request/response bundle of the serial add/sub unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface serial_addsub_ctrl_if
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sel, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, result, cout, overflow
  );

endinterface
`default_nettype wire

// File: rtl/adder_sub_1bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_sub_1bit : one-bit full adder with b inverted when sel=1
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_sub_1bit (
  input  wire logic a,
  input  wire logic b,
  input  wire logic sel,
  input  wire logic Cin,
  output logic      sum,
  output logic      Cout
);

  logic w_bx;

  assign w_bx = b ^ sel;
  assign sum  = a ^ w_bx ^ Cin;
  assign Cout = (a & w_bx) | (a & Cin) | (w_bx & Cin);

endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_addsub_ctrl : bit-serial add/subtract, LSB first, one bit per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic             clk,
  input wire logic             rst,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic             sel_q,      sel_d;
  logic             carry_q,    carry_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] res_q,      res_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic w_sum;
  logic w_cout;

  adder_sub_1bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .sel  (sel_q),
    .Cin  (carry_q),
    .sum  (w_sum),
    .Cout (w_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sel_d   = bus.sel;
          carry_d = bus.sel;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {w_sum, res_q[WIDTH-1:1]};
        carry_d = w_cout;
        cnt_d   = cnt_q + C_CNT_ONE;
        busy_d  = 1'b1;
        // carry_q is the carry into the MSB on the last bit
        if (cnt_q == C_LAST_BIT) begin
          result_d   = {w_sum, res_q[WIDTH-1:1]};
          cout_d     = w_cout;
          overflow_d = carry_q ^ w_cout;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_addsub_ctrl : directed vectors, corner sequences and full sweep
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE, check handshake timing, return outputs.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                        output logic [W-1:0] res, output logic co, output logic ov);
    int lat;
    lat       = 0;
    bus.a     = a;
    bus.b     = b;
    bus.sel   = sel;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    chk("done_latency", 32'(lat), 32'(W));
    res = bus.result;
    co  = bus.cout;
    ov  = bus.overflow;
    tick();
    chk("done_one_cycle", 32'({bus.done, bus.busy}), 32'd0);
  endtask

  vec_t         vecs [9];
  logic [W-1:0] r;
  logic         c;
  logic         o;
  int           seen;
  int           first_at;
  int           second_at;
  logic [W-1:0] first_res;
  logic [W-1:0] second_res;
  logic         idle_gap;

  initial begin
    vecs[0] = '{a: 4'd5,  b: 4'd3, sel: 1'b0, res: 4'b1000, co: 1'b0, ov: 1'b1};
    vecs[1] = '{a: 4'd5,  b: 4'd3, sel: 1'b1, res: 4'b0010, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 4'd3,  b: 4'd5, sel: 1'b1, res: 4'b1110, co: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd1, sel: 1'b0, res: 4'b0000, co: 1'b1, ov: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd1, sel: 1'b0, res: 4'b1000, co: 1'b0, ov: 1'b1};
    vecs[5] = '{a: 4'd8,  b: 4'd1, sel: 1'b1, res: 4'b0111, co: 1'b1, ov: 1'b1};
    vecs[6] = '{a: 4'd0,  b: 4'd0, sel: 1'b1, res: 4'b0000, co: 1'b1, ov: 1'b0};
    vecs[7] = '{a: 4'd8,  b: 4'd8, sel: 1'b0, res: 4'b0000, co: 1'b1, ov: 1'b1};
    vecs[8] = '{a: 4'd0,  b: 4'd0, sel: 1'b0, res: 4'b0000, co: 1'b0, ov: 1'b0};

    bus.start = 1'b0;
    bus.sel   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.result, bus.cout, bus.overflow}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, r, c, o);
      chk($sformatf("vec%0d_result", i),   32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_cout", i),     32'(c), 32'(vecs[i].co));
      chk($sformatf("vec%0d_overflow", i), 32'(o), 32'(vecs[i].ov));
    end

    // Wrap result must persist through idle cycles.
    run_op(4'd15, 4'd1, 1'b0, r, c, o);
    repeat (3) tick();
    chk("hold_idle", 32'({bus.busy, bus.result, bus.cout, bus.overflow}), 32'b0_0000_1_0);

    // Start held high, operands changed mid-run.
    seen      = 0;
    first_at  = 0;
    second_at = 0;
    first_res = '0;
    second_res = '0;
    idle_gap  = 1'b0;
    bus.a     = 4'd5;
    bus.b     = 4'd3;
    bus.sel   = 1'b0;
    bus.start = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 2) begin
        bus.a = 4'd1;
        bus.b = 4'd1;
      end
      if (i == 5) idle_gap = ~bus.busy;
      if (bus.done) begin
        seen++;
        if (seen == 1) begin
          first_at  = i;
          first_res = bus.result;
        end else if (seen == 2) begin
          second_at  = i;
          second_res = bus.result;
          bus.start  = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("held_first_at", 32'(first_at), 32'd4);
    chk("held_first_result", 32'(first_res), 32'b1000);
    chk("held_idle_gap", 32'(idle_gap), 32'd1);
    chk("held_second_at", 32'(second_at), 32'd10);
    chk("held_second_result", 32'(second_res), 32'b0010);
    chk("held_pulse_count", 32'(seen), 32'd2);
    repeat (3) tick();

    // Reset in the second RUN cycle aborts without a done pulse.
    run_op(4'd5, 4'd3, 1'b0, r, c, o);
    chk("pre_reset_outputs", 32'({r, c, o}), 32'b1000_0_1);
    bus.a     = 4'd6;
    bus.b     = 4'd1;
    bus.sel   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outputs", 32'({bus.busy, bus.done, bus.result, bus.cout, bus.overflow}), 32'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(4'd6, 4'd1, 1'b0, r, c, o);
    chk("post_abort_op", 32'({r, c, o}), 32'b0111_0_0);

    // Exhaustive sweep against an integer reference.
    for (int sel_i = 0; sel_i < 2; sel_i++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          int           sa;
          int           sb;
          int           sres;
          int           usum;
          logic [W-1:0] exp_r;
          logic         exp_c;
          logic         exp_o;
          sa    = (ai >= 8) ? ai - 16 : ai;
          sb    = (bi >= 8) ? bi - 16 : bi;
          sres  = (sel_i == 1) ? sa - sb : sa + sb;
          usum  = (sel_i == 1) ? ai + (15 - bi) + 1 : ai + bi;
          exp_r = usum[W-1:0];
          exp_c = usum[W];
          exp_o = (sres > 7) || (sres < -8);
          run_op(ai[W-1:0], bi[W-1:0], sel_i[0], r, c, o);
          chk($sformatf("sweep a=%0d b=%0d sel=%0d", ai, bi, sel_i),
              32'({r, c, o}), 32'({exp_r, exp_c, exp_o}));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
